// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_pkg
//  Description : Shared encodings for the CPU data-memory port: memOp and
//                memSize codes, the MMIO address map and the load-tracking
//                entry carried alongside each outstanding BRAM read.
//                Used by the load-return path and the store-side lane logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Memory operation codes
    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    // Access size codes; 2'b11 is not a legal size
    localparam logic [1:0] BYTE          = 2'b00;
    localparam logic [1:0] HALFWORD      = 2'b01;
    localparam logic [1:0] WORD          = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL  = 2'b11;

    // MMIO address map
    localparam logic [31:0] MMIO_EDGE_IN_ADDR = 32'h0000_A004;

    // Poison value returned for an illegal access size
    localparam logic [31:0] ILLEGAL_SIZE_DATA = 32'hDEAD_BEEF;

    // One outstanding load as it travels through the BRAM read latency.
    typedef struct packed {
        logic       valid;  // a load occupies this slot (0 = bubble)
        logic       sext;   // sign-extend the selected field
        logic [1:0] size;   // BYTE / HALFWORD / WORD / illegal
        logic [1:0] off;    // byte offset within the word (addr[1:0])
        logic       mmio;   // source is the external input register
    } track_t;

    function automatic logic is_load(input logic [1:0] op);
        return (op == MEM_READ_SEXT) || (op == MEM_READ_ZEXT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : load_formatter
//  Description : Combinational load formatting. Takes the fields recorded
//                for a load plus its source word and produces the register-
//                file value and a misaligned flag.
//                BRAM words hold byte offset k in word_i[31-8k -: 8]; the
//                MMIO word is already in CPU order, so offset k is the plain
//                little-endian lane word_i[8k +: 8]. Once the four byte lanes
//                are extracted, byte/halfword/word selection is common.
//  Ports       : sext_i       sign-extend (1) or zero-extend (0)
//                size_i       access size code
//                off_i        byte offset within the word
//                mmio_i       source word is the MMIO register
//                word_i       raw source word
//                result_o     formatted 32-bit value
//                misaligned_o access was misaligned or of illegal size
//  Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
    import mem_pkg::*;
(
    input  logic        sext_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        mmio_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o,
    output logic        misaligned_o
);

    // lane[k] is the byte at byte offset k of the addressed word
    logic [7:0]  lane [4];
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane[k] = mmio_i ? word_i[8*k +: 8] : word_i[31-8*k -: 8];
        end
    end

    always_comb begin
        half_sel     = off_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
        byte_sel     = lane[off_i];
        result_o     = '0;
        misaligned_o = 1'b0;
        case (size_i)
            BYTE: begin
                result_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            end
            HALFWORD: begin
                if (off_i[0]) begin
                    misaligned_o = 1'b1;
                end else begin
                    result_o = {{16{sext_i & half_sel[15]}}, half_sel};
                end
            end
            WORD: begin
                if (off_i != 2'b00) begin
                    misaligned_o = 1'b1;
                end else begin
                    result_o = {lane[3], lane[2], lane[1], lane[0]};
                end
            end
            default: begin
                result_o     = ILLEGAL_SIZE_DATA;
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_output_logic.sv
`default_nettype none
// ============================================================================
//  Module      : mem_output_logic
//  Description : Load-return path of the CPU data-memory port. Every issued
//                load is tracked through the BRAM port-B read latency; when
//                it emerges, the BRAM word (or the synchronised external
//                input for MMIO reads) is formatted and pushed into a small
//                skid FIFO whose head drives the outputs and which holds
//                while the consumer stalls.
//  Ports       : clk_i        system clock
//                reset_i      asynchronous active-high reset
//                addr_i       load byte address (same cycle as memOp_i)
//                memOp_i      memory operation; SEXT/ZEXT issue a load
//                memSize_i    access size
//                doutB_i      BRAM port-B read data
//                edgeIn_i     asynchronous external input word
//                stall_i      consumer not ready; FIFO head held
//                loadData_o   formatted load result (FIFO head)
//                loadValid_o  loadData_o valid
//                misaligned_o FIFO head came from a misaligned request
//                overflow_o   sticky: a return arrived while FIFO full
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_output_logic
    import mem_pkg::*;
#(
    parameter int          READ_LATENCY = 1,   // legal range 1..3
    parameter logic [31:0] MMIO_IN_ADDR = MMIO_EDGE_IN_ADDR,
    parameter int          FIFO_DEPTH   = READ_LATENCY + 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  memOp_i,
    input  logic [1:0]  memSize_i,
    input  logic [31:0] doutB_i,
    input  logic [31:0] edgeIn_i,
    input  logic        stall_i,
    output logic [31:0] loadData_o,
    output logic        loadValid_o,
    output logic        misaligned_o,
    output logic        overflow_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // Edge input synchroniser
    // ------------------------------------------------------------------
    logic [31:0] edge_meta_q;
    logic [31:0] edge_sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            edge_meta_q <= '0;
            edge_sync_q <= '0;
        end else begin
            edge_meta_q <= edgeIn_i;
            edge_sync_q <= edge_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Tracking pipe: one slot per BRAM latency cycle. It never stalls
    // because BRAM data arrives regardless; non-loads enter as bubbles.
    // ------------------------------------------------------------------
    track_t new_entry;
    track_t pipe_q [READ_LATENCY];
    track_t ret_entry;

    always_comb begin
        new_entry = '0;
        if (is_load(memOp_i)) begin
            new_entry.valid = 1'b1;
            new_entry.sext  = (memOp_i == MEM_READ_SEXT);
            new_entry.size  = memSize_i;
            new_entry.off   = addr_i[1:0];
            new_entry.mmio  = (addr_i == MMIO_IN_ADDR);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= new_entry;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign ret_entry = pipe_q[READ_LATENCY-1];

    // ------------------------------------------------------------------
    // Formatting of the returning word
    // ------------------------------------------------------------------
    logic [31:0] src_word;
    logic [31:0] fmt_data;
    logic        fmt_mis;

    assign src_word = ret_entry.mmio ? edge_sync_q : doutB_i;

    load_formatter u_load_formatter (
        .sext_i       (ret_entry.sext),
        .size_i       (ret_entry.size),
        .off_i        (ret_entry.off),
        .mmio_i       (ret_entry.mmio),
        .word_i       (src_word),
        .result_o     (fmt_data),
        .misaligned_o (fmt_mis)
    );

    // ------------------------------------------------------------------
    // Result skid FIFO
    // ------------------------------------------------------------------
    logic [31:0]      data_q [FIFO_DEPTH];
    logic             mis_q  [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      last_q, last_d;

    logic fifo_empty;
    logic fifo_full;
    logic do_push;
    logic do_pop;
    logic push_accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_push     = ret_entry.valid;
    assign do_pop      = !fifo_empty && !stall_i;
    // A pop in the same cycle frees the slot the push needs.
    assign push_accept = do_push && (!fifo_full || do_pop);

    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        if (do_pop) begin
            rd_d   = ptr_inc(rd_q);
            last_d = data_q[rd_q];
        end
        if (push_accept) begin
            wr_d = ptr_inc(wr_q);
        end
        if (push_accept && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_accept && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (do_push && !push_accept) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                mis_q[i]  <= 1'b0;
            end
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            if (push_accept) begin
                data_q[wr_q] <= fmt_data;
                mis_q[wr_q]  <= fmt_mis;
            end
        end
    end

    // When empty, loadData_o keeps showing the last consumed result.
    assign loadValid_o  = !fifo_empty;
    assign loadData_o   = fifo_empty ? last_q : data_q[rd_q];
    assign misaligned_o = !fifo_empty && mis_q[rd_q];
    assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_output_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_output_logic
//  Description : Self-checking bench for mem_output_logic. Stimulus pushes
//                expected results into a queue; a monitor compares the FIFO
//                head against the queue front whenever loadValid is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_output_logic;
    import mem_pkg::*;

    localparam int RL = 1;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [1:0]  memOp = MEM_DISABLE;
    logic [1:0]  memSize = BYTE;
    logic [31:0] doutB = '0;
    logic [31:0] edgeIn = '0;
    logic        stall = 1'b0;
    logic [31:0] loadData;
    logic        loadValid;
    logic        misaligned;
    logic        overflow;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    exp_t        exp_q[$];
    logic [31:0] sched_word [8];
    bit          sched_vld  [8];
    logic [31:0] last_popped = '0;

    always #5 clk = ~clk;

    mem_output_logic #(.READ_LATENCY(RL)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .addr_i       (addr),
        .memOp_i      (memOp),
        .memSize_i    (memSize),
        .doutB_i      (doutB),
        .edgeIn_i     (edgeIn),
        .stall_i      (stall),
        .loadData_o   (loadData),
        .loadValid_o  (loadValid),
        .misaligned_o (misaligned),
        .overflow_o   (overflow)
    );

    // Reference: the addressed word is a little-endian group of byte lanes.
    // BRAM keeps byte offset k at bits [31-8k -: 8]; MMIO at [8k +: 8].
    function automatic exp_t model(input logic [1:0] op, input logic [1:0] sz,
                                   input logic [31:0] a, input logic [31:0] bram,
                                   input logic [31:0] ext);
        exp_t        r;
        logic        mm;
        logic [31:0] src;
        logic [7:0]  lanes [4];
        logic [31:0] val;
        int          n;
        int          off;
        mm  = (a == MMIO_EDGE_IN_ADDR);
        src = mm ? ext : bram;
        off = int'(a[1:0]);
        for (int k = 0; k < 4; k++) begin
            lanes[k] = mm ? src[8*k +: 8] : src[31-8*k -: 8];
        end
        if (sz == SIZE_ILLEGAL) begin
            r.data = 32'hDEAD_BEEF;
            r.mis  = 1'b1;
        end else begin
            n = 1 << sz;
            if ((off % n) != 0) begin
                r.data = '0;
                r.mis  = 1'b1;
            end else begin
                val = '0;
                for (int i = 0; i < n; i++) begin
                    val = val | (32'(lanes[off+i]) << (8*i));
                end
                if (op == MEM_READ_SEXT && n < 4 && val[8*n-1]) begin
                    val = val | (32'hFFFF_FFFF << (8*n));
                end
                r.data = val;
                r.mis  = 1'b0;
            end
        end
        return r;
    endfunction

    // One clock cycle of stimulus. The BRAM word for a load issued now is
    // scheduled to appear on doutB RL cycles later.
    task automatic step(input logic [1:0] op, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] w,
                        input logic st, input bit model_push);
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        doutB = sched_vld[cyc % 8] ? sched_word[cyc % 8] : $urandom;
        sched_vld[cyc % 8] = 1'b0;
        memOp   = op;
        memSize = sz;
        addr    = a;
        stall   = st;
        if (op == MEM_READ_SEXT || op == MEM_READ_ZEXT) begin
            sched_word[(cyc + RL) % 8] = w;
            sched_vld[(cyc + RL) % 8]  = 1'b1;
            if (model_push) exp_q.push_back(model(op, sz, a, w, edgeIn));
        end
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(MEM_DISABLE, BYTE, '0, '0, st, 1'b0);
    endtask

    task automatic issue_fixed(input logic [1:0] op, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [31:0] fx_data, input logic fx_mis);
        exp_t e;
        step(op, sz, a, w, 1'b0, 1'b0);
        e.data = fx_data;
        e.mis  = fx_mis;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act === req) passes = passes + 1;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) sched_vld[i] = 1'b0;
        last_popped = '0;
        idle(hold, 1'b0);
        check("reset_loadData", loadData, 32'h0);
        check("reset_loadValid", 32'(loadValid), 32'h0);
        check("reset_misaligned", 32'(misaligned), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
    endtask

    task automatic random_block(input int n);
        logic        st;
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] a;
        edgeIn = $urandom;
        idle(4, 1'b0);
        for (int i = 0; i < n; i++) begin
            st = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            if (st) op = ($urandom_range(0, 1) == 0) ? MEM_WRITE : MEM_DISABLE;
            sz = ($urandom_range(0, 9) == 0) ? SIZE_ILLEGAL : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = MMIO_EDGE_IN_ADDR;
            else a = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
            step(op, sz, a, $urandom, st, 1'b1);
        end
        idle(RL + 4, 1'b0);
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: compare the FIFO head with the expected queue front.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (loadValid) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result: actual=%h/%0d required=none",
                             loadData, misaligned);
                end else begin
                    e = exp_q[0];
                    if (loadData === e.data && misaligned === e.mis) begin
                        passes = passes + 1;
                    end else begin
                        $display("FAIL result: actual=%h mis=%0d required=%h mis=%0d",
                                 loadData, misaligned, e.data, e.mis);
                    end
                    if (!stall) begin
                        last_popped = e.data;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                checks = checks + 1;
                if (misaligned === 1'b0 && loadData === last_popped) begin
                    passes = passes + 1;
                end else begin
                    $display("FAIL idle_hold: actual=%h mis=%0d required=%h mis=0",
                             loadData, misaligned, last_popped);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int i = 0; i < 8; i++) begin
            sched_vld[i]  = 1'b0;
            sched_word[i] = '0;
        end
        do_reset(3);

        // Byte load through BRAM: exact latency and one-cycle valid pulse
        issue_fixed(MEM_READ_SEXT, BYTE, 32'h3, 32'h0000_0044, 32'h0000_0044, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check("lat_not_yet", 32'(loadValid), 32'h0);
        idle(1, 1'b0);
        @(negedge clk);
        check("lat_valid", 32'(loadValid), 32'h1);
        check("lat_data", loadData, 32'h0000_0044);
        idle(1, 1'b0);
        @(negedge clk);
        check("lat_pulse_end", 32'(loadValid), 32'h0);

        // Field select and extension on a BRAM word
        issue_fixed(MEM_READ_SEXT, BYTE, 32'h13, 32'h80FF_0080, 32'hFFFF_FF80, 1'b0);
        issue_fixed(MEM_READ_ZEXT, HALFWORD, 32'h10, 32'h80FF_0080, 32'h0000_FF80, 1'b0);
        issue_fixed(MEM_READ_SEXT, WORD, 32'h10, 32'h80FF_0080, 32'h8000_FF80, 1'b0);
        issue_fixed(MEM_READ_SEXT, HALFWORD, 32'h12, 32'h0000_FFEE, 32'hFFFF_EEFF, 1'b0);
        // Misaligned and illegal size
        issue_fixed(MEM_READ_SEXT, HALFWORD, 32'h11, 32'h1234_5678, 32'h0, 1'b1);
        issue_fixed(MEM_READ_ZEXT, WORD, 32'h12, 32'h1234_5678, 32'h0, 1'b1);
        issue_fixed(MEM_READ_ZEXT, SIZE_ILLEGAL, 32'h10, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
        idle(RL + 3, 1'b0);

        // MMIO input register reads
        edgeIn = 32'hCAFE_F00D;
        idle(4, 1'b0);
        issue_fixed(MEM_READ_ZEXT, WORD, MMIO_EDGE_IN_ADDR, $urandom, 32'hCAFE_F00D, 1'b0);
        issue_fixed(MEM_READ_ZEXT, BYTE, MMIO_EDGE_IN_ADDR, $urandom, 32'h0000_000D, 1'b0);
        issue_fixed(MEM_READ_SEXT, HALFWORD, MMIO_EDGE_IN_ADDR, $urandom, 32'hFFFF_F00D, 1'b0);
        idle(RL + 3, 1'b0);

        // Back-to-back loads with a three-cycle stall at the first return
        issue_fixed(MEM_READ_ZEXT, WORD, 32'h20, 32'h1122_3344, 32'h4433_2211, 1'b0);
        issue_fixed(MEM_READ_SEXT, HALFWORD, 32'h22, 32'h0000_FFEE, 32'hFFFF_EEFF, 1'b0);
        idle(3, 1'b1);
        idle(4, 1'b0);
        check("stall_no_overflow", 32'(overflow), 32'h0);
        check("stall_drained", 32'(exp_q.size()), 32'h0);

        // Reset one cycle after issue discards the in-flight load
        step(MEM_READ_ZEXT, WORD, 32'h40, 32'h5555_AAAA, 1'b0, 1'b1);
        idle(1, 1'b0);
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            idle(1, 1'b0);
            @(negedge clk);
            check("post_reset_no_valid", 32'(loadValid), 32'h0);
        end

        // Randomised traffic against the reference model
        random_block(120);
        random_block(120);
        random_block(120);
        check("random_no_overflow", 32'(overflow), 32'h0);

        // Overflow: consumer breaks its contract and issues while stalled
        step(MEM_READ_ZEXT, WORD, 32'h50, 32'h0102_0304, 1'b1, 1'b1);
        step(MEM_READ_ZEXT, BYTE, 32'h51, 32'hA1B2_C3D4, 1'b1, 1'b1);
        step(MEM_READ_ZEXT, BYTE, 32'h52, 32'h7777_7777, 1'b1, 1'b0);
        idle(2, 1'b1);
        @(negedge clk);
        check("overflow_set", 32'(overflow), 32'h1);
        idle(4, 1'b0);
        check("overflow_sticky", 32'(overflow), 32'h1);
        check("overflow_drained", 32'(exp_q.size()), 32'h0);
        do_reset(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
